// File: rtl/iagu_depth_convolution_pkg.sv
// Shared types and encodings for the depthwise-convolution input address generator.
package iagu_depth_convolution_pkg;

  localparam int unsigned AddrW = 13;

  typedef enum logic [1:0] {
    StIdle,
    StWaitW,
    StRun,
    StEnd
  } state_e;

  localparam logic [1:0] Stride2       = 2'd2;
  localparam logic [1:0] TilePartMajor = 2'd1;

endpackage

// File: rtl/iagu_depth_convolution_if.sv
// Scheduler command/config bus and IO-buffer read outputs of the input AGU.
interface iagu_depth_convolution_if;
  import iagu_depth_convolution_pkg::*;

  logic             start_calculate;
  logic             weight_load_end;
  logic [AddrW-1:0] addr_start_d;
  logic [7:0]       in_x_length;
  logic [7:0]       in_y_length;
  logic [7:0]       in_piece;
  logic [7:0]       out_y_length;
  logic [4:0]       part_num;
  logic [3:0]       last_part;
  logic [3:0]       i_kernel;
  logic [1:0]       i_stride;
  logic [1:0]       i_pad;
  logic [1:0]       tilingtype;
  logic [AddrW-1:0] o_d_addr;
  logic             o_rd_en;
  logic             o_pad_en;
  logic             o_feature_end;

  modport master (
    output start_calculate, weight_load_end, addr_start_d, in_x_length, in_y_length,
           in_piece, out_y_length, part_num, last_part, i_kernel, i_stride, i_pad, tilingtype,
    input  o_d_addr, o_rd_en, o_pad_en, o_feature_end
  );

  modport slave (
    input  start_calculate, weight_load_end, addr_start_d, in_x_length, in_y_length,
           in_piece, out_y_length, part_num, last_part, i_kernel, i_stride, i_pad, tilingtype,
    output o_d_addr, o_rd_en, o_pad_en, o_feature_end
  );

endinterface

// File: rtl/iagu_tap_counter.sv
// Nested kx/ky/ox/oy window counter; kx is innermost, last flags the final tap of a pass.
module iagu_tap_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [3:0] k,
  input  logic [9:0] out_x,
  input  logic [7:0] rows,
  output logic [3:0] kx,
  output logic [3:0] ky,
  output logic [9:0] ox,
  output logic [7:0] oy,
  output logic       last
);

  logic [3:0] kx_q, ky_q;
  logic [9:0] ox_q;
  logic [7:0] oy_q;
  logic       kx_wrap, ky_wrap, ox_wrap;

  // Each carry already includes the inner ones, so a wrap implies all inner counters wrap.
  assign kx_wrap = kx_q == k - 4'd1;
  assign ky_wrap = kx_wrap && (ky_q == k - 4'd1);
  assign ox_wrap = ky_wrap && (ox_q == out_x - 10'd1);
  assign last    = ox_wrap && (oy_q == rows - 8'd1);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      kx_q <= '0;
      ky_q <= '0;
      ox_q <= '0;
      oy_q <= '0;
    end else if (en) begin
      kx_q <= kx_wrap ? '0 : kx_q + 4'd1;
      if (kx_wrap) ky_q <= ky_wrap ? '0 : ky_q + 4'd1;
      if (ky_wrap) ox_q <= ox_wrap ? '0 : ox_q + 10'd1;
      if (ox_wrap) oy_q <= last ? '0 : oy_q + 8'd1;
    end
  end

  assign kx = kx_q;
  assign ky = ky_q;
  assign ox = ox_q;
  assign oy = oy_q;

endmodule

// File: rtl/iagu_depth_convolution.sv
// Input AGU for depthwise convolution: per-pass window sweep with padding detection and
// IO-buffer address generation, handshaking pass-by-pass with the weight AGU.
module iagu_depth_convolution
  import iagu_depth_convolution_pkg::*;
(
  input logic                     clk,
  input logic                     rst,
  iagu_depth_convolution_if.slave bus
);

  state_e state_q, state_d;
  logic   pend_q, pend_d;
  logic   latch, emit, pass_adv, fe_d;

  logic [AddrW-1:0] base_q;
  logic [7:0]       in_x_q, in_y_q, piece_n_q, out_y_q, last_rows_q;
  logic [4:0]       part_n_q;
  logic [3:0]       k_q;
  logic [1:0]       pad_cfg_q;
  logic             stride2_q, part_major_q;

  logic [7:0] piece_q;
  logic [4:0] part_q;
  logic       last_piece, last_tile, passes_done;

  logic [3:0]       kx, ky;
  logic [9:0]       ox, out_x;
  logic [7:0]       oy, rows;
  logic             tap_last, in_range;
  logic [13:0]      row;
  logic [16:0]      iy, ix;
  logic [AddrW-1:0] piece_size, addr;

  logic [AddrW-1:0] addr_q;
  logic             rd_en_q, pad_en_q, fe_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q       <= '0;
      in_x_q       <= '0;
      in_y_q       <= '0;
      piece_n_q    <= '0;
      out_y_q      <= '0;
      last_rows_q  <= '0;
      part_n_q     <= '0;
      k_q          <= '0;
      pad_cfg_q    <= '0;
      stride2_q    <= 1'b0;
      part_major_q <= 1'b0;
    end else if (latch) begin
      base_q       <= bus.addr_start_d;
      in_x_q       <= bus.in_x_length;
      in_y_q       <= bus.in_y_length;
      piece_n_q    <= (bus.in_piece == 8'd0) ? 8'd1 : bus.in_piece;
      out_y_q      <= bus.out_y_length;
      last_rows_q  <= (bus.last_part == 4'd0) ? bus.out_y_length : {4'b0, bus.last_part};
      part_n_q     <= (bus.part_num == 5'd0) ? 5'd1 : bus.part_num;
      k_q          <= bus.i_kernel;
      pad_cfg_q    <= bus.i_pad;
      stride2_q    <= bus.i_stride == Stride2;
      part_major_q <= bus.tilingtype == TilePartMajor;
    end
  end

  assign last_piece  = piece_q == piece_n_q - 8'd1;
  assign last_tile   = part_q == part_n_q - 5'd1;
  assign passes_done = last_piece && last_tile;
  assign rows        = last_tile ? last_rows_q : out_y_q;
  assign out_x       = ((10'(in_x_q) + 10'({pad_cfg_q, 1'b0}) - 10'(k_q)) >> stride2_q) + 10'd1;
  assign piece_size  = 13'(in_x_q) * 13'(in_y_q);

  iagu_tap_counter u_tap (
    .clk   (clk),
    .rst   (rst),
    .clr   (state_q == StIdle),
    .en    (emit),
    .k     (k_q),
    .out_x (out_x),
    .rows  (rows),
    .kx    (kx),
    .ky    (ky),
    .ox    (ox),
    .oy    (oy),
    .last  (tap_last)
  );

  // Coordinates are evaluated in 17-bit two's complement so negative taps show up in bit 16.
  assign row      = 14'(part_q) * 14'(out_y_q) + 14'(oy);
  assign iy       = ({3'b0, row} << stride2_q) + 17'(ky) - 17'(pad_cfg_q);
  assign ix       = ({7'b0, ox} << stride2_q) + 17'(kx) - 17'(pad_cfg_q);
  assign in_range = !iy[16] && (iy < 17'(in_y_q)) && !ix[16] && (ix < 17'(in_x_q));
  assign addr     = base_q + piece_size * 13'(piece_q) + iy[12:0] * 13'(in_x_q) + ix[12:0];

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    latch    = 1'b0;
    emit     = 1'b0;
    pass_adv = 1'b0;
    fe_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        pend_d = 1'b0;
        if (bus.start_calculate) begin
          latch   = 1'b1;
          state_d = StWaitW;
        end
      end
      StWaitW: begin
        if (bus.weight_load_end || pend_q) begin
          pend_d  = 1'b0;
          emit    = 1'b1;
          state_d = tap_last ? StEnd : StRun;
        end
      end
      StRun: begin
        if (bus.weight_load_end) pend_d = 1'b1;
        emit = 1'b1;
        if (tap_last) state_d = StEnd;
      end
      StEnd: begin
        if (bus.weight_load_end) pend_d = 1'b1;
        fe_d     = 1'b1;
        pass_adv = 1'b1;
        state_d  = passes_done ? StIdle : StWaitW;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || latch) begin
      piece_q <= '0;
      part_q  <= '0;
    end else if (pass_adv) begin
      if (passes_done) begin
        piece_q <= '0;
        part_q  <= '0;
      end else if (part_major_q) begin
        piece_q <= last_piece ? '0 : piece_q + 8'd1;
        if (last_piece) part_q <= part_q + 5'd1;
      end else begin
        part_q <= last_tile ? '0 : part_q + 5'd1;
        if (last_tile) piece_q <= piece_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      rd_en_q  <= 1'b0;
      pad_en_q <= 1'b0;
      fe_q     <= 1'b0;
    end else begin
      addr_q   <= (emit && in_range) ? addr : '0;
      rd_en_q  <= emit && in_range;
      pad_en_q <= emit && !in_range;
      fe_q     <= fe_d;
    end
  end

  assign bus.o_d_addr      = addr_q;
  assign bus.o_rd_en       = rd_en_q;
  assign bus.o_pad_en      = pad_en_q;
  assign bus.o_feature_end = fe_q;

endmodule

// File: tb/tb_iagu_depth_convolution.sv
// Scoreboard bench for the depthwise-convolution input AGU against a loop-level tap model.
module tb_iagu_depth_convolution;
  import iagu_depth_convolution_pkg::*;

  typedef struct {
    int base; int inx; int iny; int piece; int outy; int part;
    int last; int k; int s; int p; int tt;
  } cfg_t;

  typedef struct {
    bit          rd;
    bit          pad;
    bit          fe;
    bit          follow;
    logic [12:0] addr;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  iagu_depth_convolution_if bus ();

  iagu_depth_convolution dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t sb[$];
  int   obs_addr[$];
  bit   obs_rd[$];
  int   errors = 0, checks = 0, cyc = 0, last_cyc = 0;
  int   fe_seen = 0, taps_seen = 0, reads_seen = 0, pads_seen = 0;

  always @(posedge clk) cyc++;

  // Monitor: every strobe cycle must match the next expected item, in order and back-to-back.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (bus.o_rd_en || bus.o_pad_en || bus.o_feature_end)) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: rd=%0b pad=%0b fe=%0b addr=%0d at cycle %0d, none expected",
                 bus.o_rd_en, bus.o_pad_en, bus.o_feature_end, bus.o_d_addr, cyc);
      end else begin
        e = sb.pop_front();
        if (bus.o_rd_en !== e.rd || bus.o_pad_en !== e.pad || bus.o_feature_end !== e.fe ||
            bus.o_d_addr !== e.addr || (e.follow && cyc != last_cyc + 1)) begin
          errors++;
          $display("FAIL tap_item: got rd=%0b pad=%0b fe=%0b addr=%0d gap=%0d, want rd=%0b pad=%0b fe=%0b addr=%0d contiguous=%0b",
                   bus.o_rd_en, bus.o_pad_en, bus.o_feature_end, bus.o_d_addr, cyc - last_cyc,
                   e.rd, e.pad, e.fe, e.addr, e.follow);
        end
      end
      last_cyc = cyc;
      if (bus.o_feature_end) fe_seen++;
      else begin
        taps_seen++;
        obs_addr.push_back(int'(bus.o_d_addr));
        obs_rd.push_back(bus.o_rd_en);
        if (bus.o_rd_en) reads_seen++;
        else pads_seen++;
      end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  function automatic int n_passes(input cfg_t c);
    return ((c.piece == 0) ? 1 : c.piece) * ((c.part == 0) ? 1 : c.part);
  endfunction

  // Reference model: enumerate passes and window taps straight from the loop definition.
  task automatic build(input cfg_t c);
    int np, nt, lp, st, oxn, ps, rows, r0, pc, t, iy, ix;
    bit first;
    exp_t e;
    np  = (c.piece == 0) ? 1 : c.piece;
    nt  = (c.part == 0) ? 1 : c.part;
    lp  = (c.last == 0) ? c.outy : c.last;
    st  = (c.s == 2) ? 2 : 1;
    oxn = (c.inx + 2 * c.p - c.k) / st + 1;
    ps  = (c.inx * c.iny) % 8192;
    for (int i = 0; i < np * nt; i++) begin
      if (c.tt == 1) begin t = i / np; pc = i % np; end
      else begin pc = i / nt; t = i % nt; end
      rows  = (t == nt - 1) ? lp : c.outy;
      r0    = t * c.outy;
      first = 1'b1;
      for (int oy = 0; oy < rows; oy++)
        for (int ox = 0; ox < oxn; ox++)
          for (int ky = 0; ky < c.k; ky++)
            for (int kx = 0; kx < c.k; kx++) begin
              iy = (r0 + oy) * st + ky - c.p;
              ix = ox * st + kx - c.p;
              e.fe = 1'b0;
              e.follow = !first;
              first = 1'b0;
              if (iy >= 0 && iy < c.iny && ix >= 0 && ix < c.inx) begin
                e.rd = 1'b1; e.pad = 1'b0;
                e.addr = 13'((c.base + pc * ps + iy * c.inx + ix) % 8192);
              end else begin
                e.rd = 1'b0; e.pad = 1'b1; e.addr = '0;
              end
              sb.push_back(e);
            end
      e.rd = 1'b0; e.pad = 1'b0; e.fe = 1'b1; e.follow = 1'b1; e.addr = '0;
      sb.push_back(e);
    end
  endtask

  task automatic apply(input cfg_t c);
    bus.addr_start_d = 13'(c.base);
    bus.in_x_length  = 8'(c.inx);
    bus.in_y_length  = 8'(c.iny);
    bus.in_piece     = 8'(c.piece);
    bus.out_y_length = 8'(c.outy);
    bus.part_num     = 5'(c.part);
    bus.last_part    = 4'(c.last);
    bus.i_kernel     = 4'(c.k);
    bus.i_stride     = 2'(c.s);
    bus.i_pad        = 2'(c.p);
    bus.tilingtype   = 2'(c.tt);
  endtask

  task automatic start_pulse();
    @(posedge clk); #1 bus.start_calculate = 1'b1;
    @(posedge clk); #1 bus.start_calculate = 1'b0;
  endtask

  task automatic wle_pulse(input bit check_lat);
    @(posedge clk); #1 bus.weight_load_end = 1'b1;
    @(posedge clk); #1 bus.weight_load_end = 1'b0;
    if (check_lat) chk("first_tap_latency", int'(bus.o_rd_en | bus.o_pad_en), 1);
  endtask

  task automatic wait_fe(input int target, input string name);
    for (int n = 0; n < 20000 && fe_seen < target; n++) @(posedge clk);
    chk(name, int'(fe_seen >= target), 1);
  endtask

  task automatic wait_taps(input int target);
    for (int n = 0; n < 20000 && taps_seen < target; n++) @(posedge clk);
    chk("tap_progress", int'(taps_seen >= target), 1);
  endtask

  task automatic clear_obs();
    obs_addr.delete(); obs_rd.delete();
    taps_seen = 0; reads_seen = 0; pads_seen = 0;
  endtask

  task automatic run_basic(input cfg_t c);
    int f0;
    apply(c); build(c); clear_obs();
    f0 = fe_seen;
    start_pulse();
    for (int i = 0; i < n_passes(c); i++) begin
      wle_pulse(1'b1);
      wait_fe(f0 + i + 1, "pass_end");
    end
    repeat (3) @(posedge clk);
    #1 chk("idle_after_run", int'(dut.state_q == StIdle), 1);
  endtask

  initial begin
    cfg_t c, c2;
    int f0;
    bus.start_calculate = 1'b0;
    bus.weight_load_end = 1'b0;
    c = '{base: 0, inx: 1, iny: 1, piece: 1, outy: 1, part: 1, last: 0, k: 1, s: 1, p: 0, tt: 0};
    apply(c);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_addr", int'(bus.o_d_addr), 0);
    chk("reset_strobes", int'({bus.o_rd_en, bus.o_pad_en, bus.o_feature_end}), 0);
    chk("reset_state", int'(dut.state_q == StIdle), 1);

    // Padding on a 3x3 map
    c = '{base: 100, inx: 3, iny: 3, piece: 1, outy: 3, part: 1, last: 0, k: 3, s: 1, p: 1, tt: 0};
    f0 = fe_seen;
    run_basic(c);
    chk("pad_taps", taps_seen, 81);
    chk("pad_reads", reads_seen, 49);
    chk("pad_pads", pads_seen, 32);
    chk("pad_tap5_addr", obs_addr[4], 100);
    chk("pad_tap5_rd", int'(obs_rd[4]), 1);
    chk("pad_fe_count", fe_seen - f0, 1);

    // Two pieces: the second pass needs its own weight_load_end
    c.piece = 2;
    apply(c); build(c); clear_obs();
    f0 = fe_seen;
    start_pulse();
    wle_pulse(1'b1);
    wait_fe(f0 + 1, "piece_pass0_end");
    repeat (10) @(posedge clk);
    chk("piece_waits_for_weights", taps_seen, 81);
    wle_pulse(1'b1);
    wait_fe(f0 + 2, "piece_pass1_end");
    chk("piece1_centre_addr", obs_addr[85], 109);

    // Stride 2 on a 5x5 map
    c = '{base: 200, inx: 5, iny: 5, piece: 1, outy: 3, part: 1, last: 0, k: 3, s: 2, p: 1, tt: 0};
    run_basic(c);
    chk("stride_taps", taps_seen, 81);
    chk("stride_out11_centre", obs_addr[40], 212);

    // Row tiling, both loop orders
    c = '{base: 300, inx: 5, iny: 5, piece: 2, outy: 3, part: 2, last: 2, k: 3, s: 1, p: 1, tt: 0};
    run_basic(c);
    chk("tile_piece_major_pass1", obs_addr[139], 315);
    c.tt = 1;
    run_basic(c);
    chk("tile_part_major_pass1", obs_addr[139], 325);

    // Pending flag: two pulses mid-run buy exactly one early pass
    c = '{base: 50, inx: 3, iny: 3, piece: 3, outy: 3, part: 1, last: 0, k: 3, s: 1, p: 1, tt: 0};
    apply(c); build(c); clear_obs();
    f0 = fe_seen;
    start_pulse();
    wle_pulse(1'b1);
    wait_taps(10);
    wle_pulse(1'b0);
    repeat (2) @(posedge clk);
    wle_pulse(1'b0);
    wait_fe(f0 + 1, "pend_pass0_end");
    wait_fe(f0 + 2, "pend_pass1_auto");
    repeat (10) @(posedge clk);
    chk("pend_single_early_pass", taps_seen, 162);
    wle_pulse(1'b1);
    wait_fe(f0 + 3, "pend_pass2_end");

    // Reset mid-run, then a start pulse while waiting for weights is ignored
    c  = '{base: 10, inx: 3, iny: 3, piece: 1, outy: 3, part: 1, last: 0, k: 3, s: 1, p: 1, tt: 0};
    c2 = '{base: 4000, inx: 4, iny: 2, piece: 2, outy: 1, part: 1, last: 0, k: 1, s: 2, p: 0, tt: 0};
    apply(c); build(c); clear_obs();
    f0 = fe_seen;
    start_pulse();
    wle_pulse(1'b1);
    wait_taps(20);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    sb.delete();
    chk("rst_mid_addr", int'(bus.o_d_addr), 0);
    chk("rst_mid_strobes", int'({bus.o_rd_en, bus.o_pad_en, bus.o_feature_end}), 0);
    chk("rst_mid_state", int'(dut.state_q == StIdle), 1);
    chk("rst_no_feature_end", fe_seen, f0);
    build(c); clear_obs();
    start_pulse();
    apply(c2);
    start_pulse();
    wle_pulse(1'b1);
    wait_fe(f0 + 1, "rst_restart_end");
    repeat (3) @(posedge clk);
    #1 chk("start_in_waitw_ignored", int'(dut.state_q == StIdle), 1);

    // Randomized configurations
    repeat (6) begin
      c.inx   = $urandom_range(1, 6);
      c.iny   = $urandom_range(1, 6);
      c.k     = $urandom_range(1, 3);
      c.p     = $urandom_range(0, 2);
      if (c.inx + 2 * c.p < c.k) c.p = 2;
      c.s     = $urandom_range(0, 3);
      c.piece = $urandom_range(0, 3);
      c.outy  = $urandom_range(1, 4);
      c.part  = $urandom_range(0, 3);
      c.last  = $urandom_range(0, 4);
      c.tt    = $urandom_range(0, 3);
      c.base  = $urandom_range(0, 8191);
      run_basic(c);
    end

    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
